// File: rtl/muldiv_seq.sv
// muldiv_seq -- multi-cycle sequencer for the MULT / DIV R-type ops.
//   Iterative shift-add multiply and restoring divide, one iteration per clock,
//   WIDTH iterations per op. Holds Stall so a single-cycle core waits; the
//   core resumes when Done pulses. Hi/Lo keep their last result until the
//   next Done.
// Configuration:
//   MULDIV_SIGNED_EN  defined -> two's-complement operands (magnitudes are
//                     iterated, signs fixed up on the final edge).
//                     undefined -> purely unsigned, no sign logic.
// Ports:
//   clk, rst_n   rising-edge clock, async active-low reset
//   Start        request, sampled only in IDLE or DONE
//   Itr[5:0]     funct: 011000 MULT, 011010 DIV, anything else ignored
//   A, B         rs / rt operands, latched on the accepting edge
//   Busy         high while iterating
//   Done         one-cycle pulse, Hi/Lo valid from this cycle on
//   Stall        Busy, or a request that will be accepted this cycle
//   Hi, Lo       MULT: product high/low; DIV: remainder/quotient
//   DivZero      DIV with B==0; cleared by the next accepted op
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [5:0]       Itr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivZero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t r_state, w_next;

  logic             w_is_mul, w_is_div, w_accept, w_bzero, w_last;
  logic [CW-1:0]    r_cnt;
  // r_ph/r_pl: MUL -> running {product_hi, multiplier/product_lo};
  //            DIV -> running {remainder, dividend/quotient}
  logic [WIDTH-1:0] r_ph, r_pl, r_d;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_divzero;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;

  assign w_is_mul = (Itr == F_MULT);
  assign w_is_div = (Itr == F_DIV);
  assign w_bzero  = (B == '0);
  assign w_last   = (r_cnt == '0);
  assign w_accept = Start & (w_is_mul | w_is_div) &
                    ((r_state == S_IDLE) | (r_state == S_DONE));

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    Busy   = 1'b0;
    Done   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        Done = (r_state == S_DONE);
        if (w_accept)
          // divide by zero skips the iterations entirely
          w_next = w_is_mul ? S_MUL : (w_bzero ? S_DONE : S_DIV);
        else if (r_state == S_DONE)
          w_next = S_IDLE;
      end
      S_MUL, S_DIV: begin
        Busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
    Stall = Busy | w_accept;
  end

  // ---------------- sign handling ----------------
`ifdef MULDIV_SIGNED_EN
  logic w_sa, w_sb, r_sa, r_sb;
  assign w_sa    = A[WIDTH-1];
  assign w_sb    = B[WIDTH-1];
  assign w_a_mag = w_sa ? (~A + 1'b1) : A;
  assign w_b_mag = w_sb ? (~B + 1'b1) : B;
`else
  assign w_a_mag = A;
  assign w_b_mag = B;
`endif

  // ---------------- one iteration ----------------
  // multiply: conditionally add multiplicand into the high half, shift right
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_mul_hi, w_mul_lo;
  assign w_sum    = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_d} : '0);
  assign w_mul_hi = w_sum[WIDTH:1];
  assign w_mul_lo = {w_sum[0], r_pl[WIDTH-1:1]};

  // divide: shift next dividend bit into the remainder, subtract if it fits
  logic [WIDTH:0]     w_shift;
  logic               w_fit;
  logic [WIDTH-1:0]   w_rem, w_quo;
  assign w_shift = {r_ph, r_pl[WIDTH-1]};
  assign w_fit   = (w_shift >= {1'b0, r_d});
  assign w_rem   = w_fit ? WIDTH'(w_shift - {1'b0, r_d}) : w_shift[WIDTH-1:0];
  assign w_quo   = {r_pl[WIDTH-2:0], w_fit};

  // final-edge results, sign-corrected when enabled
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_fin_rem, w_fin_quo;
`ifdef MULDIV_SIGNED_EN
  assign w_prod    = (r_sa ^ r_sb) ? (~{w_mul_hi, w_mul_lo} + 1'b1) : {w_mul_hi, w_mul_lo};
  assign w_fin_quo = (r_sa ^ r_sb) ? (~w_quo + 1'b1) : w_quo;
  assign w_fin_rem = r_sa ? (~w_rem + 1'b1) : w_rem;
`else
  assign w_prod    = {w_mul_hi, w_mul_lo};
  assign w_fin_quo = w_quo;
  assign w_fin_rem = w_rem;
`endif

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph      <= '0;
      r_pl      <= '0;
      r_d       <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_divzero <= 1'b0;
    end else if (w_accept) begin
      r_ph      <= '0;
      r_pl      <= w_a_mag;
      r_d       <= w_b_mag;
      r_cnt     <= CW'(WIDTH - 1);
      r_divzero <= w_is_div & w_bzero;
      if (w_is_div & w_bzero) begin
        r_hi <= A;            // raw A, even in signed mode
        r_lo <= '1;
      end
    end else if (r_state == S_MUL) begin
      r_ph  <= w_mul_hi;
      r_pl  <= w_mul_lo;
      r_cnt <= r_cnt - 1'b1;
      if (w_last) {r_hi, r_lo} <= w_prod;
    end else if (r_state == S_DIV) begin
      r_ph  <= w_rem;
      r_pl  <= w_quo;
      r_cnt <= r_cnt - 1'b1;
      if (w_last) begin
        r_hi <= w_fin_rem;
        r_lo <= w_fin_quo;
      end
    end
  end

`ifdef MULDIV_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa <= 1'b0;
      r_sb <= 1'b0;
    end else if (w_accept) begin
      r_sa <= w_sa;
      r_sb <= w_sb;
    end
  end
`endif

  assign Hi      = r_hi;
  assign Lo      = r_lo;
  assign DivZero = r_divzero;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq (WIDTH=32) against a plain
// arithmetic reference model. Define MULDIV_SIGNED_EN for both files to
// exercise the signed build.
module tb_muldiv_seq;
  localparam int W = 32;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;

  logic         clk = 1'b0, rst_n = 1'b0, Start = 1'b0;
  logic [5:0]   Itr = '0;
  logic [W-1:0] A = '0, B = '0;
  logic         Busy, Done, Stall, DivZero;
  logic [W-1:0] Hi, Lo;

  int n_chk = 0, n_fail = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Itr(Itr), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Stall(Stall), .Hi(Hi), .Lo(Lo), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: straight arithmetic on 64-bit values
  function automatic void model(input logic [5:0] itr, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
`endif
    dz = 1'b0;
    if (itr == F_MULT) begin
`ifdef MULDIV_SIGNED_EN
      p = 64'(sa * sb);
`else
      p = {32'b0, a} * {32'b0, b};
`endif
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == '0) begin
      hi = a;
      lo = '1;
      dz = 1'b1;
    end else begin
`ifdef MULDIV_SIGNED_EN
      lo = W'(sa / sb);
      hi = W'(sa % sb);
`else
      lo = a / b;
      hi = a % b;
`endif
    end
  endfunction

  // Issue one op from IDLE or DONE (#1 after an edge); returns in its Done cycle.
  task automatic run_op(input logic [5:0] itr, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el, ph, pl;
    logic         ed;
    int           cnt, busy_cnt, lat;
    model(itr, a, b, eh, el, ed);
    ph = Hi; pl = Lo;
    Start = 1'b1; Itr = itr; A = a; B = b;
    #1 chk("stall_on_request", Stall, 1);
    @(posedge clk); #1;
    Start = 1'b0;
    cnt = 0; busy_cnt = 0;
    while (!Done && cnt < 40) begin
      if (Busy) busy_cnt++;
      chk("stall_eq_busy", Stall, Busy);
      if (cnt == 5) begin
        chk("hold_hi", Hi, ph);
        chk("hold_lo", Lo, pl);
      end
      // scramble operands and fire ignorable requests while iterating
      A = $urandom; B = $urandom;
      if (cnt < 30) begin
        Start = 1'($urandom_range(0, 1));
        Itr   = $urandom_range(0, 1) ? F_DIV : F_MULT;
      end else
        Start = 1'b0;
      @(posedge clk); #1;
      cnt++;
    end
    Start = 1'b0;
    lat = ed ? 0 : W;
    chk("done", Done, 1);
    chk("latency", cnt, lat);
    chk("busy_cycles", busy_cnt, lat);
    chk("busy_at_done", Busy, 0);
    chk("hi", Hi, eh);
    chk("lo", Lo, el);
    chk("divzero", DivZero, ed);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    chk("idle_done", Done, 0);
    chk("idle_busy", Busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] a, b, sh, sl;
    logic [5:0]   itr;

    // reset state
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_hi", Hi, 0);
    chk("rst_lo", Lo, 0);
    chk("rst_divzero", DivZero, 0);
    chk("rst_stall", Stall, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // directed cases
    run_op(F_MULT, 32'd7, 32'd6);
    go_idle();
    run_op(F_DIV, 32'd100, 32'd7);
    run_op(F_DIV, 32'd5, 32'd0);            // back-to-back from DONE
    run_op(F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF); // clears DivZero, max product
    run_op(F_DIV, 32'hFFFFFFFF, 32'd1);
    go_idle();

    // invalid funct is ignored
    sh = Hi; sl = Lo;
    Start = 1'b1; Itr = 6'b100000; A = 32'd9; B = 32'd3;
    #1 chk("invalid_stall", Stall, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("invalid_done", Done, 0);
    chk("invalid_busy", Busy, 0);
    chk("invalid_hi", Hi, sh);
    chk("invalid_lo", Lo, sl);
    Start = 1'b0;

`ifdef MULDIV_SIGNED_EN
    run_op(F_MULT, -32'sd6, 32'sd7);
    chk("signed_mul_lo_const", Lo, 32'hFFFFFFD6);
    run_op(F_DIV, -32'sd7, 32'sd2);
    chk("signed_div_lo_const", Lo, 32'hFFFFFFFD);
    run_op(F_DIV, 32'sd7, -32'sd2);
    run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    go_idle();
`endif

    // randomized ops
    for (int i = 0; i < 24; i++) begin
      itr = $urandom_range(0, 1) ? F_DIV : F_MULT;
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 255));
      run_op(itr, a, b);
      if ($urandom_range(0, 1) == 1) go_idle();
    end

    // reset in the middle of a divide
    Start = 1'b1; Itr = F_DIV; A = 32'd1000; B = 32'd3;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_hi", Hi, 0);
    chk("abort_lo", Lo, 0);
    chk("abort_divzero", DivZero, 0);
    #2 rst_n = 1'b1;
    go_idle();
    run_op(F_DIV, 32'd1000, 32'd3);
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
